// File: rtl/writeback_ctrl.sv
// Writeback stage: data-memory wait FSM, load extraction, register-file write
// selection, retire counting and memory-response timeout detection.
module writeback_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic             wb_is_load,
  input  logic             wb_is_store,
  input  logic [2:0]       wb_funct3,
  input  logic [1:0]       wb_addr_lo,
  input  logic [4:0]       wb_rd_s,
  input  logic             wb_regf_we,
  input  logic [31:0]      wb_alu_result,
  input  logic [31:0]      d_mem_rdata,
  input  logic             d_mem_resp,
  output logic             freeze,
  output logic             rd_we,
  output logic [4:0]       rd_s,
  output logic [31:0]      rd_v,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic             mem_timeout
);

  localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  retire_count_q, retire_count_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic              mem_op_s;
  logic              commit_s;
  logic              freeze_s;
  logic [32:0]       load_res_s;
  logic              rd_we_s;

  // Returns {funct3_is_legal_load, extended_value}.
  function automatic logic [32:0] load_extract(
    input logic [2:0]  funct3,
    input logic [1:0]  addr_lo,
    input logic [31:0] word
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [32:0] res;
    case (addr_lo)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      3'b000:  res = {1'b1, {24{byte_v[7]}}, byte_v};
      3'b001:  res = {1'b1, {16{half_v[15]}}, half_v};
      3'b010:  res = {1'b1, word};
      3'b100:  res = {1'b1, 24'd0, byte_v};
      3'b101:  res = {1'b1, 16'd0, half_v};
      default: res = {1'b0, 32'd0};
    endcase
    return res;
  endfunction

  // Wait FSM next state, freeze and commit decision.
  always_comb begin
    mem_op_s      = wb_valid & (wb_is_load | wb_is_store);
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    freeze_s      = 1'b0;
    commit_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s) begin
          if (d_mem_resp) begin
            commit_s = 1'b1;
          end else begin
            freeze_s = 1'b1;
            state_d  = ST_WAIT;
            wcnt_d   = '0;
          end
        end else if (wb_valid) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (d_mem_resp) begin
          commit_s = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          freeze_s = 1'b1;
          if (wcnt_q != TIMEOUT_C) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end else begin
            wcnt_d = wcnt_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    mem_timeout_d  = mem_timeout_q | ((state_q == ST_WAIT) & (wcnt_d == TIMEOUT_C));
    // Gate with reset so an asserted rst drops freeze without waiting for an edge.
    freeze         = freeze_s & rst;
    retire         = commit_s & rst;
    retire_count_d = retire_count_q + CNT_W'(retire);
  end

  // Register-file write port selection.
  always_comb begin
    load_res_s = load_extract(wb_funct3, wb_addr_lo, d_mem_rdata);
    rd_we_s    = retire & wb_regf_we & ~wb_is_store & (wb_rd_s != 5'd0)
               & (~wb_is_load | load_res_s[32]);
    rd_we      = rd_we_s;
    if (rd_we_s) begin
      rd_s = wb_rd_s;
      rd_v = wb_is_load ? load_res_s[31:0] : wb_alu_result;
    end else begin
      rd_s = 5'd0;
      rd_v = 32'd0;
    end
  end

  // State, wait counter, retire counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      wcnt_q         <= '0;
      retire_count_q <= '0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      retire_count_q <= retire_count_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  assign retire_count = retire_count_q;
  assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Randomized scoreboard bench for writeback_ctrl: a transaction-level model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_writeback_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             wb_valid, wb_is_load, wb_is_store, wb_regf_we, d_mem_resp;
  logic [2:0]       wb_funct3;
  logic [1:0]       wb_addr_lo;
  logic [4:0]       wb_rd_s;
  logic [31:0]      wb_alu_result, d_mem_rdata;
  logic             freeze, rd_we, retire, mem_timeout;
  logic [4:0]       rd_s;
  logic [31:0]      rd_v;
  logic [CNT_W-1:0] retire_count;

  writeback_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_is_load(wb_is_load),
    .wb_is_store(wb_is_store), .wb_funct3(wb_funct3), .wb_addr_lo(wb_addr_lo),
    .wb_rd_s(wb_rd_s), .wb_regf_we(wb_regf_we), .wb_alu_result(wb_alu_result),
    .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp), .freeze(freeze),
    .rd_we(rd_we), .rd_s(rd_s), .rd_v(rd_v), .retire(retire),
    .retire_count(retire_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        load;
    logic        store;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu;
    logic [31:0] rdata;
  } instr_t;

  typedef struct packed {
    logic             freeze;
    logic             retire;
    logic             rd_we;
    logic [4:0]       rd_s;
    logic [31:0]      rd_v;
    logic [CNT_W-1:0] count;
    logic             timeout;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cnt_model = 0;
  bit          sticky = 1'b0;
  logic [31:0] last_rd_v = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {we, rd, value} of a committing instruction, from the ISA rules.
  function automatic logic [37:0] model_wb(input instr_t i);
    logic [31:0] b, h, v;
    bit ok, we;
    b  = (i.rdata >> (8 * i.lo)) & 32'hFF;
    h  = (i.rdata >> (16 * i.lo[1])) & 32'hFFFF;
    ok = 1'b1;
    case (i.f3)
      3'd0:    v = (b ^ 32'h80) - 32'h80;
      3'd1:    v = (h ^ 32'h8000) - 32'h8000;
      3'd2:    v = i.rdata;
      3'd4:    v = b;
      3'd5:    v = h;
      default: begin v = 32'd0; ok = 1'b0; end
    endcase
    if (!i.load) v = i.alu;
    we = i.we && !i.store && (i.rd != 5'd0) && (!i.load || ok);
    return we ? {1'b1, i.rd, v} : 38'd0;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int vf[5] = '{0, 1, 2, 4, 5};
    int kind = $urandom_range(0, 2);
    i.load  = (kind == 1);
    i.store = (kind == 2);
    i.f3    = ($urandom_range(0, 4) != 0) ? 3'(vf[$urandom_range(0, 4)]) : 3'($urandom);
    i.lo    = 2'($urandom);
    i.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    i.we    = ($urandom_range(0, 4) != 0);
    i.alu   = $urandom;
    i.rdata = $urandom;
    return i;
  endfunction

  task automatic drive(input instr_t i, input logic valid, input logic resp, input logic [31:0] rdata);
    wb_valid = valid; wb_is_load = i.load; wb_is_store = i.store; wb_funct3 = i.f3;
    wb_addr_lo = i.lo; wb_rd_s = i.rd; wb_regf_we = i.we; wb_alu_result = i.alu;
    d_mem_resp = resp; d_mem_rdata = rdata;
  endtask

  task automatic push(input logic fr, input logic ret, input logic [37:0] wbv, input logic to);
    exp_t e;
    e.freeze = fr; e.retire = ret;
    {e.rd_we, e.rd_s, e.rd_v} = wbv;
    e.count = CNT_W'(cnt_model);
    e.timeout = to;
    exp_q.push_back(e);
  endtask

  task automatic idle_body();
    drive(rand_instr(), 1'b0, 1'($urandom), $urandom);
    push(1'b0, 1'b0, 38'd0, sticky);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    idle_body();
  endtask

  // One instruction; memory ops see their response lat cycles after issue.
  task automatic run_instr(input instr_t i, input int lat);
    bit mem = i.load || i.store;
    int last = mem ? lat : 0;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      drive(i, 1'b1, mem ? 1'(c == last) : 1'($urandom), (c == last) ? i.rdata : $urandom);
      push(mem && (c < last), c == last, (c == last) ? model_wb(i) : 38'd0,
           sticky || (mem && c >= TIMEOUT + 1));
    end
    cnt_model++;
    if (mem && lat >= TIMEOUT + 1) sticky = 1'b1;
  endtask

  task automatic random_phase(input int n, input int max_lat);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      else run_instr(rand_instr(), $urandom_range(0, max_lat));
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("freeze", 32'(freeze), 32'(e.freeze));
      check("retire", 32'(retire), 32'(e.retire));
      check("rd_we", 32'(rd_we), 32'(e.rd_we));
      check("rd_s", 32'(rd_s), 32'(e.rd_s));
      check("rd_v", rd_v, e.rd_v);
      check("retire_count", 32'(retire_count), 32'(e.count));
      check("mem_timeout", 32'(mem_timeout), 32'(e.timeout));
      if (retire) last_rd_v = rd_v;
    end
  end

  initial begin
    instr_t i;
    rst = 1'b0;
    drive('0, 1'b0, 1'b0, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      push(1'b0, 1'b0, 38'd0, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    idle_body();

    i = '0; i.we = 1'b1; i.rd = 5'd5; i.alu = 32'h1234;
    run_instr(i, 0);
    idle_cycle();

    i = '0; i.load = 1'b1; i.f3 = 3'd0; i.lo = 2'd2; i.rd = 5'd7; i.we = 1'b1;
    i.rdata = 32'h0080_0000;
    run_instr(i, 3);
    @(negedge clk); #1;
    check("lb_value", last_rd_v, 32'hFFFF_FF80);

    i = '0; i.load = 1'b1; i.f3 = 3'd5; i.lo = 2'd2; i.rd = 5'd9; i.we = 1'b1;
    i.rdata = 32'hBEEF_0000;
    run_instr(i, 0);
    @(negedge clk); #1;
    check("lhu_value", last_rd_v, 32'h0000_BEEF);

    i = '0; i.store = 1'b1; i.f3 = 3'd2; i.rd = 5'd3; i.we = 1'b1;
    run_instr(i, 1);
    i = '0; i.we = 1'b1; i.rd = 5'd0; i.alu = 32'hDEAD;
    run_instr(i, 0);

    random_phase(400, TIMEOUT);

    i = '0; i.load = 1'b1; i.f3 = 3'd2; i.rd = 5'd12; i.we = 1'b1; i.rdata = 32'hCAFE_F00D;
    run_instr(i, 6);
    repeat (3) idle_cycle();
    random_phase(20, 3);

    i = '0; i.load = 1'b1; i.f3 = 3'd2; i.rd = 5'd4; i.we = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      drive(i, 1'b1, 1'b0, $urandom);
      push(1'b1, 1'b0, 38'd0, sticky);
    end
    @(negedge clk); #2;
    check("pre_rst_freeze", 32'(freeze), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_count", 32'(retire_count), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    cnt_model = 0;
    sticky = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      push(1'b0, 1'b0, 38'd0, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    idle_body();

    random_phase(100, TIMEOUT);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
